axi_slave_fsm_r_resp: RTL and testbench

AXI_SLAVE_FSM_R_RESP -- requirements
Module: axi_slave_fsm_r_resp

---
 rtl/axi_slave_fsm_r_resp.sv | 219 +++++++++++++++++++++
 tb/tb_axi_slave_fsm_r_resp.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_slave_fsm_r_resp.sv
// rtl/axi_slave_fsm_r_resp.sv - AXI slave read-response FSM: R FIFO to R channel, optional SLVERR beat injection
// Optional feature macro: AXI_SLAVE_R_ERR_EN (error capture slot and R_Err state)
module axi_slave_fsm_r_resp #(
    parameter int ID_W   = 5,
    parameter int DATA_W = 64
) (
    input  logic                   axi_clk,
    input  logic                   ARESTn,
    input  logic [ID_W+DATA_W+2:0] FIFO_rd_data,
    input  logic                   FIFO_empty,
    output logic                   FIFO_rd_en,
    input  logic                   int_RVALID,
    input  logic [ID_W-1:0]        int_RID,
    output logic                   int_ready,
    output logic                   RVALID,
    input  logic                   RREADY,
    output logic [ID_W-1:0]        RID,
    output logic [DATA_W-1:0]      RDATA,
    output logic [1:0]             RRESP,
    output logic                   RLAST,
    output logic                   rd_done,
    output logic [ID_W-1:0]        rd_done_id
);

`ifdef AXI_SLAVE_R_ERR_EN
    typedef enum logic [1:0] {
        R_Idle = 2'd0,
        R_Data = 2'd1,
        R_Err  = 2'd2
    } r_state_t;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
`else
    typedef enum logic [1:0] {
        R_Idle = 2'd0,
        R_Data = 2'd1
    } r_state_t;
`endif

    r_state_t            r_state;
    logic                r_rvalid;
    logic [ID_W-1:0]     r_rid;
    logic [DATA_W-1:0]   r_rdata;
    logic [1:0]          r_rresp;
    logic                r_rlast;
    logic                r_rd_done;
    logic [ID_W-1:0]     r_rd_done_id;
    logic                r_in_burst;

    // FWFT word layout: {RID, RDATA, RRESP, RLAST}
    logic [ID_W-1:0]     w_fifo_rid;
    logic [DATA_W-1:0]   w_fifo_data;
    logic [1:0]          w_fifo_resp;
    logic                w_fifo_last;
    logic                w_pop;

    assign w_fifo_rid  = FIFO_rd_data[ID_W+DATA_W+2:DATA_W+3];
    assign w_fifo_data = FIFO_rd_data[DATA_W+2:3];
    assign w_fifo_resp = FIFO_rd_data[2:1];
    assign w_fifo_last = FIFO_rd_data[0];

`ifdef AXI_SLAVE_R_ERR_EN
    logic                r_err_pending;
    logic [ID_W-1:0]     r_err_id;
    logic                w_err_go;
    logic                w_err_clr;

    assign w_err_clr = (r_state == R_Err) && RREADY;
    // int_ready is the slot's emptiness straight from the register, so a
    // slot freed this cycle cannot be refilled until the next one
    assign int_ready = !r_err_pending;

    // One-deep capture of a rejected read's ID from the AR side
    always_ff @(posedge axi_clk or negedge ARESTn) begin
        if (!ARESTn) begin
            r_err_pending <= 1'b0;
            r_err_id      <= '0;
        end else if (w_err_clr) begin
            r_err_pending <= 1'b0;
        end else if (int_RVALID && !r_err_pending) begin
            r_err_pending <= 1'b1;
            r_err_id      <= int_RID;
        end
    end
`else
    logic w_unused_err_inputs;

    assign w_unused_err_inputs = &{1'b0, int_RVALID, int_RID};
    assign int_ready           = 1'b1;
`endif

    // Next-beat selection: pop only when the output register is free or
    // being emptied this cycle; an error beat only at a burst boundary
    always_comb begin
        w_pop = 1'b0;
`ifdef AXI_SLAVE_R_ERR_EN
        w_err_go = 1'b0;
`endif
        case (r_state)
            R_Idle: begin
                w_pop = !FIFO_empty;
`ifdef AXI_SLAVE_R_ERR_EN
                if (r_err_pending && !r_in_burst) begin
                    w_pop    = 1'b0;
                    w_err_go = 1'b1;
                end
`endif
            end
            R_Data: begin
                if (RREADY) begin
                    w_pop = !FIFO_empty;
`ifdef AXI_SLAVE_R_ERR_EN
                    if (r_rlast && r_err_pending) begin
                        w_pop    = 1'b0;
                        w_err_go = 1'b1;
                    end
`endif
                end
            end
            default: begin
                w_pop = 1'b0;
            end
        endcase
    end

    // Pop is the combinational strobe that pairs with the FWFT load edge;
    // reset forces it low so nothing is consumed while held in reset
    assign FIFO_rd_en = w_pop && ARESTn;

    // Main FSM with registered R payload, burst tracking and completion pulse
    always_ff @(posedge axi_clk or negedge ARESTn) begin
        if (!ARESTn) begin
            r_state      <= R_Idle;
            r_rvalid     <= 1'b0;
            r_rid        <= '0;
            r_rdata      <= '0;
            r_rresp      <= 2'b00;
            r_rlast      <= 1'b0;
            r_rd_done    <= 1'b0;
            r_rd_done_id <= '0;
            r_in_burst   <= 1'b0;
        end else begin
            r_rd_done <= 1'b0;
            case (r_state)
                R_Idle: begin
`ifdef AXI_SLAVE_R_ERR_EN
                    if (w_err_go) begin
                        r_rvalid <= 1'b1;
                        r_rid    <= r_err_id;
                        r_rdata  <= '0;
                        r_rresp  <= RESP_SLVERR;
                        r_rlast  <= 1'b1;
                        r_state  <= R_Err;
                    end else
`endif
                    if (w_pop) begin
                        r_rvalid <= 1'b1;
                        r_rid    <= w_fifo_rid;
                        r_rdata  <= w_fifo_data;
                        r_rresp  <= w_fifo_resp;
                        r_rlast  <= w_fifo_last;
                        r_state  <= R_Data;
                    end
                end
                R_Data: begin
                    if (RREADY) begin
                        if (r_rlast) begin
                            r_in_burst   <= 1'b0;
                            r_rd_done    <= 1'b1;
                            r_rd_done_id <= r_rid;
                        end else begin
                            r_in_burst   <= 1'b1;
                        end
`ifdef AXI_SLAVE_R_ERR_EN
                        if (w_err_go) begin
                            r_rid    <= r_err_id;
                            r_rdata  <= '0;
                            r_rresp  <= RESP_SLVERR;
                            r_rlast  <= 1'b1;
                            r_state  <= R_Err;
                        end else
`endif
                        if (w_pop) begin
                            r_rid    <= w_fifo_rid;
                            r_rdata  <= w_fifo_data;
                            r_rresp  <= w_fifo_resp;
                            r_rlast  <= w_fifo_last;
                        end else begin
                            r_rvalid <= 1'b0;
                            r_state  <= R_Idle;
                        end
                    end
                end
`ifdef AXI_SLAVE_R_ERR_EN
                R_Err: begin
                    if (RREADY) begin
                        r_rd_done    <= 1'b1;
                        r_rd_done_id <= r_rid;
                        r_rvalid     <= 1'b0;
                        r_state      <= R_Idle;
                    end
                end
`endif
                default: begin
                    r_rvalid <= 1'b0;
                    r_state  <= R_Idle;
                end
            endcase
        end
    end

    assign RVALID     = r_rvalid;
    assign RID        = r_rid;
    assign RDATA      = r_rdata;
    assign RRESP      = r_rresp;
    assign RLAST      = r_rlast;
    assign rd_done    = r_rd_done;
    assign rd_done_id = r_rd_done_id;

endmodule

// File: tb/tb_axi_slave_fsm_r_resp.sv
// tb/tb_axi_slave_fsm_r_resp.sv - scoreboard bench for axi_slave_fsm_r_resp
module tb_axi_slave_fsm_r_resp;
    localparam int ID_W   = 5;
    localparam int DATA_W = 64;
    localparam int WW     = ID_W + DATA_W + 3;
`ifdef AXI_SLAVE_R_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    typedef struct packed {
        logic [ID_W-1:0]   b_id;
        logic [DATA_W-1:0] b_data;
        logic [1:0]        b_resp;
        logic              b_last;
    } beat_t;

    logic                axi_clk = 1'b0;
    logic                ARESTn;
    logic [WW-1:0]       FIFO_rd_data;
    logic                FIFO_empty;
    logic                FIFO_rd_en;
    logic                int_RVALID;
    logic [ID_W-1:0]     int_RID;
    logic                int_ready;
    logic                RVALID;
    logic                RREADY;
    logic [ID_W-1:0]     RID;
    logic [DATA_W-1:0]   RDATA;
    logic [1:0]          RRESP;
    logic                RLAST;
    logic                rd_done;
    logic [ID_W-1:0]     rd_done_id;

    always #5 axi_clk = ~axi_clk;

    axi_slave_fsm_r_resp #(.ID_W(ID_W), .DATA_W(DATA_W)) dut (
        .axi_clk(axi_clk), .ARESTn(ARESTn),
        .FIFO_rd_data(FIFO_rd_data), .FIFO_empty(FIFO_empty), .FIFO_rd_en(FIFO_rd_en),
        .int_RVALID(int_RVALID), .int_RID(int_RID), .int_ready(int_ready),
        .RVALID(RVALID), .RREADY(RREADY), .RID(RID), .RDATA(RDATA),
        .RRESP(RRESP), .RLAST(RLAST), .rd_done(rd_done), .rd_done_id(rd_done_id)
    );

    beat_t           fifo_q[$];
    beat_t           exp_q[$];
    logic [ID_W-1:0] done_q[$];
    int              n_chk = 0;
    int              n_err = 0;
    int              pops  = 0;
    logic            m_pend;
    logic            exp_done_now;
    logic            last_rd_en, last_rvalid, last_done, last_int_ready;
    logic [ID_W-1:0] last_done_id;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic fifo_drive();
        FIFO_empty   = (fifo_q.size() == 0);
        FIFO_rd_data = FIFO_empty ? '0 : fifo_q[0];
    endtask

    task automatic push_word(input logic [ID_W-1:0] id, input logic [DATA_W-1:0] d,
                             input logic [1:0] resp, input logic last);
        beat_t b;
        b.b_id = id; b.b_data = d; b.b_resp = resp; b.b_last = last;
        fifo_q.push_back(b);
        exp_q.push_back(b);
        if (last) done_q.push_back(id);
        fifo_drive();
    endtask

    task automatic push_err(input logic [ID_W-1:0] id);
        beat_t b;
        b.b_id = id; b.b_data = '0; b.b_resp = 2'b10; b.b_last = 1'b1;
        exp_q.push_back(b);
        done_q.push_back(id);
    endtask

    // one clock: sample at negedge+1, check, then advance to the next negedge
    task automatic run_cycle();
        beat_t obs, e;
        logic  acc, rde, done_next, pend_next;
        #1;
        obs  = {RID, RDATA, RRESP, RLAST};
        acc  = (RVALID === 1'b1) && RREADY;
        rde  = FIFO_rd_en;
        last_rd_en = rde; last_rvalid = RVALID; last_done = rd_done;
        last_done_id = rd_done_id; last_int_ready = int_ready;
        chk("pop_when_empty", rde & FIFO_empty, 1'b0);
        chk("pop_while_held", rde & RVALID & !RREADY, 1'b0);
        chk("int_ready", int_ready, !m_pend);
        chk("done_pulse", rd_done, exp_done_now);
        if (rd_done === 1'b1 && done_q.size() != 0) chk("done_id", rd_done_id, done_q.pop_front());
        if (RVALID === 1'b1) begin
            if (exp_q.size() != 0) chk("beat", obs, exp_q[0]);
            else chk("rvalid_unexpected", RVALID, 1'b0);
        end
        done_next = 1'b0;
        pend_next = m_pend;
        if (ERR_EN && int_RVALID && !m_pend) pend_next = 1'b1;
        if (acc && exp_q.size() != 0) begin
            e = exp_q.pop_front();
            done_next = e.b_last;
            if (e.b_resp == 2'b10) pend_next = 1'b0;
        end
        if (rde) pops++;
        @(posedge axi_clk);
        @(negedge axi_clk);
        if (rde && fifo_q.size() != 0) void'(fifo_q.pop_front());
        fifo_drive();
        exp_done_now = done_next;
        m_pend       = pend_next;
    endtask

    task automatic drain(input string tag);
        RREADY = 1'b1;
        for (int i = 0; i < 60 && (exp_q.size() != 0 || done_q.size() != 0 || exp_done_now); i++)
            run_cycle();
        chk(tag, exp_q.size() + done_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int vmask, cnt, p0;
        ARESTn = 1'b0; RREADY = 1'b0; int_RVALID = 1'b0; int_RID = '0;
        m_pend = 1'b0; exp_done_now = 1'b0;
        fifo_drive();
        #1;
        chk("rst_rvalid", RVALID, 1'b0);
        chk("rst_payload", {RID, RDATA, RRESP, RLAST}, '0);
        chk("rst_rd_en", FIFO_rd_en, 1'b0);
        chk("rst_done", {rd_done, rd_done_id}, '0);
        chk("rst_int_ready", int_ready, 1'b1);
        @(negedge axi_clk); @(negedge axi_clk);
        ARESTn = 1'b1;

        // single beat: pop, RVALID one cycle later, completion pulse with ID 3
        RREADY = 1'b1;
        push_word(5'd3, 64'hA5, 2'b00, 1'b1);
        run_cycle();
        chk("a_pop", last_rd_en, 1'b1);
        chk("a_rvalid_lat", last_rvalid, 1'b0);
        run_cycle();
        chk("a_rvalid", last_rvalid, 1'b1);
        chk("a_single_pop", last_rd_en, 1'b0);
        run_cycle();
        chk("a_done", last_done, 1'b1);
        chk("a_done_id", last_done_id, 5'd3);

        // 4-beat burst pre-filled: four back-to-back beats, one completion
        RREADY = 1'b0;
        for (int i = 0; i < 4; i++) push_word(5'd5, 64'h100 + i, 2'b00, i == 3);
        run_cycle();
        RREADY = 1'b1;
        vmask = 0; cnt = 0;
        for (int i = 0; i < 6; i++) begin
            run_cycle();
            if (last_rvalid === 1'b1) vmask |= (1 << i);
            if (last_done === 1'b1) cnt++;
        end
        chk("b_rvalid_run", vmask, 6'b001111);
        chk("b_done_count", cnt, 1);

        // backpressure: payload held 5 cycles, no pop while held
        RREADY = 1'b0;
        push_word(5'd9, 64'hDEAD_BEEF_0123_4567, 2'b01, 1'b1);
        push_word(5'd10, 64'h0F0F_0F0F_F0F0_F0F0, 2'b00, 1'b1);
        run_cycle();
        p0 = pops; cnt = 0;
        for (int i = 0; i < 5; i++) begin
            run_cycle();
            if (last_rvalid === 1'b1) cnt++;
        end
        chk("c_held_valid", cnt, 5);
        chk("c_no_pop", pops - p0, 0);
        drain("c_drain");

        // error request during beat 2 of a 4-beat burst
        RREADY = 1'b1;
        for (int i = 0; i < 4; i++) push_word(5'd12, 64'h200 + i, 2'b00, i == 3);
        run_cycle();
        run_cycle();
        int_RVALID = 1'b1; int_RID = 5'd7;
        run_cycle();
        int_RVALID = 1'b0; int_RID = '0;
        if (ERR_EN) push_err(5'd7);
        run_cycle();
        chk("d_int_ready_busy", last_int_ready, !ERR_EN);
        drain("d_drain");

        // FIFO runs dry mid-burst, error arrives in the gap
        RREADY = 1'b1;
        push_word(5'd14, 64'h300, 2'b00, 1'b0);
        push_word(5'd14, 64'h301, 2'b00, 1'b0);
        for (int i = 0; i < 4; i++) run_cycle();
        int_RVALID = 1'b1; int_RID = 5'd20;
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            run_cycle();
            int_RVALID = 1'b0;
            if (last_rvalid === 1'b1) cnt++;
        end
        chk("e_gap", cnt, 0);
        push_word(5'd14, 64'h302, 2'b00, 1'b0);
        push_word(5'd14, 64'h303, 2'b00, 1'b1);
        if (ERR_EN) push_err(5'd20);
        drain("e_drain");

        // error request with the channel idle and no burst open
        int_RVALID = 1'b1; int_RID = 5'd21;
        run_cycle();
        int_RVALID = 1'b0;
        if (ERR_EN) push_err(5'd21);
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            run_cycle();
            if (last_rvalid === 1'b1) cnt++;
        end
        chk("g_idle_err_beats", cnt, ERR_EN ? 1 : 0);
        drain("g_drain");

        // random backpressure over mixed bursts
        push_word(5'd1, {$urandom, $urandom}, 2'b00, 1'b1);
        for (int i = 0; i < 3; i++) push_word(5'd2, {$urandom, $urandom}, 2'b01, i == 2);
        for (int i = 0; i < 2; i++) push_word(5'd3, {$urandom, $urandom}, 2'b00, i == 1);
        for (int i = 0; i < 80 && (exp_q.size() != 0 || done_q.size() != 0 || exp_done_now); i++) begin
            RREADY = 1'($urandom_range(0, 1));
            run_cycle();
        end
        chk("f_drain", exp_q.size() + done_q.size(), 0);

        // asynchronous reset while a beat is held
        RREADY = 1'b0;
        push_word(5'd17, 64'h4444, 2'b00, 1'b1);
        run_cycle();
        int_RVALID = 1'b1; int_RID = 5'd9;
        run_cycle();
        int_RVALID = 1'b0;
        chk("h_rvalid_before", last_rvalid, 1'b1);
        push_word(5'd18, 64'h5555, 2'b00, 1'b1);
        #2;
        ARESTn = 1'b0;
        #1;
        chk("h_rvalid", RVALID, 1'b0);
        chk("h_payload", {RID, RDATA, RRESP, RLAST}, '0);
        chk("h_rd_en", FIFO_rd_en, 1'b0);
        chk("h_done", {rd_done, rd_done_id}, '0);
        chk("h_int_ready", int_ready, 1'b1);
        exp_q.delete(); done_q.delete();
        m_pend = 1'b0; exp_done_now = 1'b0;
        @(negedge axi_clk);
        p0 = pops;
        run_cycle();
        run_cycle();
        chk("h_no_pop_in_reset", pops - p0, 0);
        fifo_q.delete();
        fifo_drive();
        ARESTn = 1'b1;
        for (int i = 0; i < 3; i++) run_cycle();
        chk("h_idle_after", last_rvalid, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
